// File: rtl/lsu_byte_sequencer_pkg.sv
// lsu_pkg: shared types and helpers for the LSU byte sequencer.
// Contents: access-size enum, FSM state enum, beats-per-access and
// alignment-check functions.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_BEAT,
    ST_RESP
  } state_e;

  // Number of byte beats (1, 2 or 4) for an access size.
  function automatic logic [2:0] beat_count(input logic [1:0] size);
    logic [2:0] cnt;
    case (size)
      SZ_B:    cnt = 3'd1;
      SZ_H:    cnt = 3'd2;
      default: cnt = 3'd4;
    endcase
    return cnt;
  endfunction

  // High when the access is misaligned. Size 2'b11 has no legal
  // encoding, so it is rejected here as well.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_sequencer_if.sv
// lsu_byte_sequencer_if: all non-clock signals of the byte sequencer.
// Groups: req_*/rsp_* (core LSU port), mem_* (8-bit memory bus),
// stg_* (LSU staging register). master = sequencer, slave = environment.
interface lsu_byte_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic              stg_wr_en;
  logic              stg_wb_sel;
  logic [1:0]        stg_byte_sel;
  logic [7:0]        stg_d_byte;
  logic [31:0]       stg_d_word;
  logic [31:0]       stg_q_load;
  logic [31:0]       stg_q_store;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_err, rsp_rdata,
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output stg_wr_en, stg_wb_sel, stg_byte_sel, stg_d_byte, stg_d_word,
    input  stg_q_load, stg_q_store
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_err, rsp_rdata,
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  stg_wr_en, stg_wb_sel, stg_byte_sel, stg_d_byte, stg_d_word,
    output stg_q_load, stg_q_store
  );

endinterface

// File: rtl/lsu_byte_sequencer_load_ext.sv
// lsu_load_ext: sign/zero extension of the staging register load view.
// Ports: q (staging contents), size (B/H/W), is_unsigned, data (result).
// Purely combinational; bytes above the access size are ignored.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] q,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic fill_b;
  logic fill_h;

  assign fill_b = ~is_unsigned & q[7];
  assign fill_h = ~is_unsigned & q[15];

  always_comb begin
    data = q;
    case (size)
      SZ_B:    data = {{24{fill_b}}, q[7:0]};
      SZ_H:    data = {{16{fill_h}}, q[15:0]};
      default: data = q;
    endcase
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer: splits LSU byte/half/word requests into 8-bit
// memory beats, staging load bytes / store words in the LSU register.
// Ports: clk, rst (async, active-high), bus (lsu_byte_sequencer_if.master).
// Optional macro LSU_SEQ_TIMEOUT_EN: per-beat wait timeout (TIMEOUT_CYC).
module lsu_byte_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  lsu_byte_sequencer_if.master bus
);

  state_e            state;
  logic [1:0]        n;
  logic [1:0]        last_q;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              mem_valid_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;

  logic [1:0]        beat_last;
  logic [31:0]       ext_data;
  logic              preload;
  logic              load_wr;

`ifdef LSU_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  assign beat_last = 2'(beat_count(bus.req_size) - 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      n           <= 2'd0;
      last_q      <= 2'd0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      mem_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef LSU_SEQ_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // req_ready is just "IDLE and not in reset", so valid alone
          // completes the handshake here.
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            last_q  <= beat_last;
            n       <= 2'd0;
`ifdef LSU_SEQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (bus.req_we) begin
              state <= ST_PRELOAD;
            end else begin
              state       <= ST_BEAT;
              mem_valid_q <= 1'b1;
            end
          end
        end

        ST_PRELOAD: begin
          state       <= ST_BEAT;
          mem_valid_q <= 1'b1;
        end

        ST_BEAT: begin
          if (bus.mem_ready) begin
`ifdef LSU_SEQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            if (n == last_q) begin
              state       <= ST_RESP;
              mem_valid_q <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
            end else begin
              n <= n + 2'd1;
            end
          end
`ifdef LSU_SEQ_TIMEOUT_EN
          else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
            state       <= ST_RESP;
            mem_valid_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          state       <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
        end

        default: begin
          state       <= ST_IDLE;
          mem_valid_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  lsu_load_ext u_load_ext (
    .q           (bus.stg_q_load),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (ext_data)
  );

  assign bus.req_ready = (state == ST_IDLE) && !rst;

  // Beat fields derive only from registered state, so they hold steady
  // for as long as mem_ready stays low.
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_valid_q & we_q;
  assign bus.mem_addr  = mem_valid_q ? (addr_q + ADDR_W'(n)) : '0;
  assign bus.mem_wdata = (mem_valid_q && we_q) ? bus.stg_q_store[{n, 3'b000} +: 8] : 8'h00;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_valid_q & rsp_err_q;
  assign bus.rsp_rdata = (rsp_valid_q && !rsp_err_q && !we_q) ? ext_data : 32'd0;

  // Staging writes: a whole-word preload for stores, one lane per
  // accepted read beat for loads. Idle values are forced to zero.
  assign preload = (state == ST_PRELOAD);
  assign load_wr = mem_valid_q && !we_q && bus.mem_ready;

  assign bus.stg_wr_en    = preload | load_wr;
  assign bus.stg_wb_sel   = preload;
  assign bus.stg_byte_sel = load_wr ? n : 2'd0;
  assign bus.stg_d_byte   = load_wr ? bus.mem_rdata : 8'h00;
  assign bus.stg_d_word   = preload ? wdata_q : 32'd0;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// tb_lsu_byte_sequencer: directed bench for lsu_byte_sequencer.
// Models the staging register and a byte memory; drives requests and
// checks beat fields, staging writes and responses cycle by cycle.
module tb_lsu_byte_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lsu_byte_sequencer_if #(.ADDR_W(32)) bus ();

  lsu_byte_sequencer #(
    .ADDR_W      (32),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] stg;
  logic [7:0]  memarr [0:4095];
  int          checks = 0;
  int          errors = 0;

  assign bus.stg_q_load  = stg;
  assign bus.stg_q_store = stg;
  assign bus.mem_rdata   = memarr[bus.mem_addr[11:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg <= 32'd0;
    end else if (bus.stg_wr_en) begin
      if (bus.stg_wb_sel) stg <= bus.stg_d_word;
      else                stg[{bus.stg_byte_sel, 3'b000} +: 8] <= bus.stg_d_byte;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; returns in cycle T+1.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] lw_word;
    logic [31:0] sw_word;
    int          waited;

    lw_word = 32'h12345678;
    sw_word = 32'hCAFEF00D;

    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.mem_ready    = 1'b1;
    memarr[12'h100]  = 8'h78;
    memarr[12'h101]  = 8'h56;
    memarr[12'h102]  = 8'h34;
    memarr[12'h103]  = 8'h12;

    // Reset state
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_stg_wr_en", 32'(bus.stg_wr_en), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // LW 0x100, zero wait
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("lw_mem_valid", 32'(bus.mem_valid), 32'd1);
      check("lw_mem_addr", bus.mem_addr, 32'(32'h100 + i));
      check("lw_mem_we", 32'(bus.mem_we), 32'd0);
      check("lw_stg_wr_en", 32'(bus.stg_wr_en), 32'd1);
      check("lw_stg_byte_sel", 32'(bus.stg_byte_sel), 32'(i));
      check("lw_stg_d_byte", 32'(bus.stg_d_byte), 32'(lw_word[8*i +: 8]));
      tick();
    end
    check("lw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("lw_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("lw_rsp_rdata", bus.rsp_rdata, 32'h12345678);
    check("lw_mem_idle", 32'(bus.mem_valid), 32'd0);
    tick();
    check("lw_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

    // LB / LBU 0x103 with byte 0x80
    memarr[12'h103] = 8'h80;
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'd0);
    check("lb_mem_addr", bus.mem_addr, 32'h103);
    check("lb_stg_byte_sel", 32'(bus.stg_byte_sel), 32'd0);
    check("lb_stg_d_byte", 32'(bus.stg_d_byte), 32'h80);
    tick();
    check("lb_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("lb_rsp_rdata", bus.rsp_rdata, 32'hFFFFFF80);
    tick();
    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'd0);
    tick();
    check("lbu_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("lbu_rsp_rdata", bus.rsp_rdata, 32'h00000080);
    tick();

    // SH 0x202, wdata 0xDEADBEEF
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'hDEADBEEF);
    check("sh_pre_wr_en", 32'(bus.stg_wr_en), 32'd1);
    check("sh_pre_wb_sel", 32'(bus.stg_wb_sel), 32'd1);
    check("sh_pre_d_word", bus.stg_d_word, 32'hDEADBEEF);
    check("sh_pre_mem_valid", 32'(bus.mem_valid), 32'd0);
    tick();
    check("sh_b0_valid", 32'(bus.mem_valid), 32'd1);
    check("sh_b0_we", 32'(bus.mem_we), 32'd1);
    check("sh_b0_addr", bus.mem_addr, 32'h202);
    check("sh_b0_wdata", 32'(bus.mem_wdata), 32'hEF);
    check("sh_b0_stg_wr_en", 32'(bus.stg_wr_en), 32'd0);
    tick();
    check("sh_b1_addr", bus.mem_addr, 32'h203);
    check("sh_b1_wdata", 32'(bus.mem_wdata), 32'hBE);
    tick();
    check("sh_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("sh_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("sh_rsp_rdata", bus.rsp_rdata, 32'd0);
    tick();

    // Misaligned: LW 0x101, LH 0x201, size 11
    issue(1'b0, 2'b10, 1'b0, 32'h101, 32'd0);
    check("mis_w_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("mis_w_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("mis_w_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("mis_w_mem_valid", 32'(bus.mem_valid), 32'd0);
    tick();
    check("mis_w_after_valid", 32'(bus.mem_valid), 32'd0);
    check("mis_w_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    issue(1'b0, 2'b01, 1'b0, 32'h201, 32'd0);
    check("mis_h_rsp_err", 32'(bus.rsp_err), 32'd1);
    tick();
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'd0);
    check("mis_sz11_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("mis_sz11_mem_valid", 32'(bus.mem_valid), 32'd0);
    tick();

    // SW 0x300 with mem_ready low for 3 cycles on beat 1
    issue(1'b1, 2'b10, 1'b0, 32'h300, sw_word);
    tick();
    check("sw_b0_addr", bus.mem_addr, 32'h300);
    check("sw_b0_wdata", 32'(bus.mem_wdata), 32'h0D);
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #0;
      check("sw_stall_valid", 32'(bus.mem_valid), 32'd1);
      check("sw_stall_addr", bus.mem_addr, 32'h301);
      check("sw_stall_wdata", 32'(bus.mem_wdata), 32'hF0);
      check("sw_stall_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    bus.mem_ready = 1'b1;
    check("sw_b1_addr", bus.mem_addr, 32'h301);
    tick();
    check("sw_b2_addr", bus.mem_addr, 32'h302);
    check("sw_b2_wdata", 32'(bus.mem_wdata), 32'hFE);
    tick();
    check("sw_b3_addr", bus.mem_addr, 32'h303);
    check("sw_b3_wdata", 32'(bus.mem_wdata), 32'hCA);
    tick();
    check("sw_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("sw_rsp_err", 32'(bus.rsp_err), 32'd0);
    tick();

    // Reset pulsed mid-beat, then a fresh LW
    memarr[12'h103] = 8'h12;
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    tick();
    check("abort_pre_valid", 32'(bus.mem_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #0;
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check("abort_no_beat", 32'(bus.mem_valid), 32'd0);
      tick();
    end
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
    tick();
    tick();
    tick();
    tick();
    check("fresh_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("fresh_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("fresh_rsp_rdata", bus.rsp_rdata, 32'h12345678);
    tick();

`ifdef LSU_SEQ_TIMEOUT_EN
    // mem_ready stuck low: response after 255 wait cycles
    bus.mem_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'd0);
    waited = 0;
    while (!bus.rsp_valid && waited < 400) begin
      tick();
      waited++;
    end
    check("tmo_wait_cycles", 32'(waited), 32'd255);
    check("tmo_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("tmo_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("tmo_mem_valid", 32'(bus.mem_valid), 32'd0);
    bus.mem_ready = 1'b1;
    tick();
`else
    waited = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
